// File: rtl/trace_capture_buffer.sv
// Instruction-trace recorder: circular (pc, instr) buffer with a wrap/stop-when-full
// policy, a PC-match trigger followed by a post-trigger window, and a FWFT readout port.
module trace_capture_buffer #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 16,
  parameter int PCW   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_valid,
  input  logic [XLEN-1:0]            cap_pc,
  input  logic [ILEN-1:0]            cap_instr,
  input  logic                       cfg_wrap,
  input  logic                       trig_en,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic [PCW-1:0]             post_count,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [XLEN-1:0]            rd_pc,
  output logic [ILEN-1:0]            rd_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       overflow,
  output logic                       triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_POST  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [ILEN-1:0] instr_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [1:0]      state_r;
  logic [PCW-1:0]  remain_r;
  logic            overflow_r;
  logic            triggered_r;

  logic active_s;
  logic cap_s;
  logic pop_s;
  logic full_s;
  logic accept_s;
  logic overwrite_s;
  logic drop_s;
  logic hit_s;

  // Capture/pop qualification; arm discards any capture or pop in its cycle
  always_comb begin
    active_s    = (state_r == S_ARMED) || (state_r == S_POST);
    cap_s       = cap_valid & active_s & ~arm;
    pop_s       = (count_r != {CW{1'b0}}) & rd_ready & ~arm;
    full_s      = (count_r == CW'(DEPTH));
    accept_s    = cap_s & (~full_s | pop_s);
    overwrite_s = cap_s & full_s & ~pop_s & cfg_wrap;
    drop_s      = cap_s & full_s & ~pop_s & ~cfg_wrap;
    hit_s       = trig_en & (cap_pc == trig_pc);
  end

  // Trace storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (accept_s | overwrite_s) begin
      pc_mem_r[wr_ptr_r]    <= cap_pc;
      instr_mem_r[wr_ptr_r] <= cap_instr;
    end
  end

  // Pointers, occupancy and overflow flag; an overwrite pushes the oldest entry out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else if (arm) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (accept_s | overwrite_s)
        wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s | overwrite_s)
        rd_ptr_r <= rd_ptr_r + AW'(1);
      if (accept_s & ~pop_s)
        count_r <= count_r + CW'(1);
      else if (pop_s & ~accept_s)
        count_r <= count_r - CW'(1);
      if (overwrite_s | drop_s)
        overflow_r <= 1'b1;
    end
  end

  // Capture FSM; dropped captures in POST still consume the post-trigger window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      remain_r    <= {PCW{1'b0}};
      triggered_r <= 1'b0;
    end else if (arm) begin
      state_r     <= S_ARMED;
      remain_r    <= {PCW{1'b0}};
      triggered_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: state_r <= S_IDLE;
        S_ARMED: begin
          if (stop) begin
            state_r <= S_IDLE;
          end else if (cap_s & hit_s) begin
            triggered_r <= 1'b1;
            if (post_count == {PCW{1'b0}}) begin
              state_r <= S_DONE;
            end else begin
              state_r  <= S_POST;
              remain_r <= post_count;
            end
          end
        end
        S_POST: begin
          if (stop) begin
            state_r <= S_IDLE;
          end else if (cap_s) begin
            remain_r <= remain_r - PCW'(1);
            if (remain_r == PCW'(1))
              state_r <= S_DONE;
          end
        end
        S_DONE: begin
          if (stop)
            state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign rd_valid  = (count_r != {CW{1'b0}});
  assign rd_pc     = rd_valid ? pc_mem_r[rd_ptr_r]    : {XLEN{1'b0}};
  assign rd_instr  = rd_valid ? instr_mem_r[rd_ptr_r] : {ILEN{1'b0}};
  assign count     = count_r;
  assign state     = state_r;
  assign overflow  = overflow_r;
  assign triggered = triggered_r;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer (DEPTH=8): expected pops are queued by the
// stimulus and a negedge monitor pops and compares whenever a transfer happens.
module tb_trace_capture_buffer;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 8;
  localparam int PCW   = 8;
  localparam logic [31:0] IMASK = 32'hCAFE_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [ILEN-1:0] cap_instr;
  logic            cfg_wrap;
  logic            trig_en;
  logic [XLEN-1:0] trig_pc;
  logic [PCW-1:0]  post_count;
  logic            arm;
  logic            stop;
  logic            rd_ready;
  logic            rd_valid;
  logic [XLEN-1:0] rd_pc;
  logic [ILEN-1:0] rd_instr;
  logic [3:0]      count;
  logic [1:0]      state;
  logic            overflow;
  logic            triggered;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  trace_capture_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cfg_wrap(cfg_wrap), .trig_en(trig_en), .trig_pc(trig_pc), .post_count(post_count),
    .arm(arm), .stop(stop), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .count(count), .state(state), .overflow(overflow),
    .triggered(triggered)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a transfer happens at the next posedge when valid&ready and no arm
  always @(negedge clk) begin
    if (!rst && !arm && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h expected=none", rd_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", rd_pc, mon_e);
        chk("pop_instr", rd_instr, mon_e ^ IMASK);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic capture(input logic [31:0] pc);
    cap_valid = 1'b1;
    cap_pc    = pc;
    cap_instr = pc ^ IMASK;
    cyc();
    cap_valid = 1'b0;
  endtask

  task automatic capture_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) capture(start + 32'(4 * i));
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drain(input string name);
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && count != 4'd0; i++) cyc();
    rd_ready = 1'b0;
    chk({name, "_drained"}, 32'(count), 32'd0);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_rd_pc_zero"}, rd_pc, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cfg_wrap = 1'b0;
    trig_en = 1'b0; trig_pc = '0; post_count = '0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_flags", {30'd0, overflow, triggered}, 32'd0);
    chk("rst_rd_pc", rd_pc, 32'd0);
    cyc();
    rst = 1'b0;

    // Wrap: 10 captures into 8 slots keep the newest 8
    cfg_wrap = 1'b1;
    pulse_arm();
    chk("t1_armed", 32'(state), 32'd1);
    capture_run(32'h00, 10);
    chk("t1_count", 32'(count), 32'd8);
    chk("t1_overflow", 32'(overflow), 32'd1);
    push_run(32'h08, 8);
    drain("t1");

    // Stop-when-full: keep the oldest 8
    cfg_wrap = 1'b0;
    pulse_arm();
    chk("t2_ovf_cleared", 32'(overflow), 32'd0);
    capture_run(32'h00, 10);
    chk("t2_count", 32'(count), 32'd8);
    chk("t2_overflow", 32'(overflow), 32'd1);
    push_run(32'h00, 8);
    drain("t2");

    // Full with simultaneous capture and pop: accepted, no overflow
    pulse_arm();
    capture_run(32'h100, 8);
    chk("t5_full", 32'(count), 32'd8);
    push_run(32'h100, 9);
    cap_valid = 1'b1; cap_pc = 32'h120; cap_instr = 32'h120 ^ IMASK; rd_ready = 1'b1;
    cyc();
    cap_valid = 1'b0; rd_ready = 1'b0;
    chk("t5_count", 32'(count), 32'd8);
    chk("t5_overflow", 32'(overflow), 32'd0);
    drain("t5");

    // Trigger with post_count=2
    cfg_wrap = 1'b1; trig_en = 1'b1; trig_pc = 32'h40; post_count = 8'd2;
    pulse_arm();
    capture_run(32'h38, 3);
    chk("t3_post", 32'(state), 32'd2);
    chk("t3_triggered", 32'(triggered), 32'd1);
    capture(32'h44);
    chk("t3_post2", 32'(state), 32'd2);
    capture(32'h48);
    chk("t3_done", 32'(state), 32'd3);
    capture(32'h4C);
    chk("t3_count", 32'(count), 32'd5);
    push_run(32'h38, 5);
    drain("t3");

    // Trigger with post_count=0
    post_count = 8'd0;
    pulse_arm();
    chk("t4_trig_cleared", 32'(triggered), 32'd0);
    capture(32'h3C);
    capture(32'h40);
    chk("t4_done", 32'(state), 32'd3);
    capture(32'h44);
    chk("t4_count", 32'(count), 32'd2);
    push_run(32'h3C, 2);
    drain("t4");

    // stop returns to IDLE, IDLE ignores captures, arm beats stop
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_idle", 32'(state), 32'd0);
    capture(32'h50);
    chk("idle_ignores", 32'(count), 32'd0);
    arm = 1'b1; stop = 1'b1;
    cyc();
    arm = 1'b0; stop = 1'b0;
    chk("arm_wins", 32'(state), 32'd1);

    // Mid-cycle asynchronous reset, then arm flush with a discarded pop
    trig_en = 1'b0;
    capture_run(32'h200, 5);
    chk("t6_count5", 32'(count), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_state", 32'(state), 32'd0);
    cyc();
    rst = 1'b0;
    pulse_arm();
    capture_run(32'h300, 3);
    chk("t6_count3", 32'(count), 32'd3);
    arm = 1'b1; rd_ready = 1'b1;
    cyc();
    arm = 1'b0; rd_ready = 1'b0;
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_state", 32'(state), 32'd1);
    chk("t6_flush_valid", 32'(rd_valid), 32'd0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
